mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single physical memory port between the pipeline's instruction-fetch and data-access interfaces. When only one requester is pending it gets the port. When both are pending, round-robin chooses between them. The arbiter latches the winning request and drives the memory until `mem_resp`, then routes the response back to the requester that owns it. It sits between the core datapath (`inst_*`, `data_*`) and the memory model (`mem_*`) at the top level.

## Interface
Parameters:
- none (address/data width fixed at 32, `rv32i_word`)

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge
- `rst`  in  1  — asynchronous, active-high reset
- `inst_read`  in  1  — instruction fetch request, level, held until `inst_resp`
- `inst_addr`  in  32  — fetch address
- `inst_resp`  out  1  — fetch complete, one-cycle pulse
- `inst_rdata`  out  32  — fetch data, valid when `inst_resp`
- `data_read`  in  1  — data load request, level, held until `data_resp`
- `data_write`  in  1  — data store request, level, held until `data_resp`
- `data_mbe`  in  4  — store byte enables
- `data_addr`  in  32  — data address
- `data_wdata`  in  32  — store data
- `data_resp`  out  1  — data access complete, one-cycle pulse
- `data_rdata`  out  32  — load data, valid when `data_resp`
- `mem_read`  out  1  — memory read strobe
- `mem_write`  out  1  — memory write strobe
- `mem_mbe`  out  4  — memory byte enables
- `mem_addr`  out  32  — memory address
- `mem_wdata`  out  32  — memory write data
- `mem_resp`  in  1  — memory completion
- `mem_rdata`  in  32  — memory read data

## Operation
- **FSM states:**
  - IDLE: port free; arbitrate.
  - INST: serving a fetch.
  - DATA: serving a load or store.
- **Request definitions:**
  - `inst_req` = `inst_read`.
  - `data_req` = `data_read | data_write`.
- **Arbitration in IDLE** (registered decision):
  - Only `inst_req` → INST.
  - Only `data_req` → DATA.
  - Both → the requester opposite `last_grant`.
  - Neither → stay IDLE.
- **`last_grant`:**
  - Updated on every transition out of IDLE.
  - Reset value INST, so the first simultaneous contention goes to data.
- **Latching on transition out of IDLE:**
  - Latch address, wdata, mbe and op (read/write) into holding registers.
  - `mem_*` outputs are driven only from these registers. Requester input changes during a transaction have no effect.
- **Fetch latch values:** op = read, mbe = 4'b1111, wdata = 0.
- **Simultaneous `data_read` and `data_write`:**
  - Illegal.
  - The arbiter performs a write.
  - A simulation assertion fires.
- **In INST/DATA:**
  - `mem_read`/`mem_write` are held high until `mem_resp`.
  - On `mem_resp`, the owner's `*_resp` = 1 combinationally in the same cycle, and the state returns to IDLE.
- **Read data routing:**
  - `inst_rdata` = `data_rdata` = `mem_rdata` (passthrough).
  - Only the resp strobes are steered.
- **Spurious responses:** `mem_resp` in IDLE is ignored; no `*_resp` is asserted.
- **Read-only memory signals:** `mem_wdata` and `mem_mbe` are don't-care during reads, but are driven from the latch (never X after reset).

## Timing
- **Reset values** (immediate, asynchronous):
  - state = IDLE, `last_grant` = INST.
  - `mem_read` = `mem_write` = 0, `mem_addr` = `mem_wdata` = 0, `mem_mbe` = 0.
  - `inst_resp` = `data_resp` = 0.
- **Reset mid-transaction:**
  - Strobes drop in the reset cycle.
  - No resp is delivered.
  - The outstanding memory access is abandoned.
- **Latency:**
  - Request visible in IDLE at cycle 0 → `mem_*` strobe at cycle 1.
  - Memory responds at cycle k ≥ 1 → requester resp at cycle k.
  - Minimum transaction length is 2 cycles.
- **Back-to-back transactions:**
  - One IDLE cycle follows every response.
  - Requests are sampled in that IDLE cycle. A requester that keeps its request high after resp gets a new transaction.
- **Strobe polarity:** `mem_read` and `mem_write` are never both 1.
- **Loser behaviour:** a pending, ungranted requester simply waits (no resp). It must keep its request stable.
- **Starvation bound:** under continuous contention, grants strictly alternate, so neither side waits more than one transaction.

## Test plan
- **Reset:**
  - Assert `rst` mid-cycle.
  - Required: all `mem_*` outputs and both resps are 0 immediately. After release with no requests, the outputs stay 0.
- **Lone fetch:**
  - `inst_read`=1, `inst_addr`=0x60; memory responds 3 cycles after `mem_read` with `mem_rdata`=0x00000013.
  - Required: `mem_read`=1 and `mem_addr`=0x60 from cycle 1. `inst_resp` pulses once with `inst_rdata`=0x13. `data_resp` stays 0.
- **Store:**
  - `data_write`=1, `data_addr`=0x100, `data_wdata`=0xDEADBEEF, `data_mbe`=4'b0011.
  - Change `data_wdata` to 0 while the store is outstanding.
  - Required: `mem_write` is held with 0xDEADBEEF and mbe 0011 until `mem_resp`. `data_resp` pulses once.
- **Contention:**
  - `inst_read` and `data_read` both held continuously from reset, for 4 transactions.
  - Required grant order: DATA, INST, DATA, INST. Exactly one IDLE cycle between each.
- **Reset mid-transaction:**
  - Data read in progress; assert `rst` before `mem_resp`.
  - Required: no `data_resp`. `mem_read` drops immediately. After reset, a new fetch completes normally.
- **Spurious response and illegal request:**
  - Pulse `mem_resp` in IDLE.
  - Required: no resp is produced.
  - Then assert `data_read` and `data_write` together.
  - Required: `mem_write`=1, `mem_read`=0, and the assertion fires.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Round-robin on contention; the winning request is latched and held on mem_* until mem_resp.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        INST,
        DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;
    state_t      last_grant;
    state_t      last_grant_nxt;
    logic        inst_req;
    logic        data_req;
    logic        load_inst;
    logic        load_data;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_mbe;
    logic        hold_write;

    assign inst_req = inst_read;
    assign data_req = data_read | data_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= INST;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_mbe   <= '0;
            hold_write <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (load_inst) begin
                hold_addr  <= inst_addr;
                hold_wdata <= '0;
                hold_mbe   <= 4'b1111;
                hold_write <= 1'b0;
            end else if (load_data) begin
                hold_addr  <= data_addr;
                hold_wdata <= data_wdata;
                hold_mbe   <= data_mbe;
                // An illegal read+write request resolves to a write.
                hold_write <= data_write;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        load_inst      = 1'b0;
        load_data      = 1'b0;
        inst_resp      = 1'b0;
        data_resp      = 1'b0;
        case (state)
            IDLE: begin
                if (inst_req && (!data_req || last_grant == DATA)) begin
                    state_nxt      = INST;
                    last_grant_nxt = INST;
                    load_inst      = 1'b1;
                end else if (data_req) begin
                    state_nxt      = DATA;
                    last_grant_nxt = DATA;
                    load_data      = 1'b1;
                end
            end
            INST: begin
                inst_resp = mem_resp;
                if (mem_resp) state_nxt = IDLE;
            end
            DATA: begin
                data_resp = mem_resp;
                if (mem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_read   = (state != IDLE) && !hold_write;
    assign mem_write  = (state != IDLE) && hold_write;
    assign mem_addr   = hold_addr;
    assign mem_wdata  = hold_wdata;
    assign mem_mbe    = hold_mbe;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    illegal_read_write_a: assert property (@(posedge clk) disable iff (rst) !(data_read && data_write))
        else $warning("mem_port_arbiter: data_read and data_write asserted together; performing write");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_read = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [3:0]  data_mbe = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_addr(inst_addr), .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Every task starts and ends 1 time unit after a rising edge, with the DUT idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        inst_read = 1'b1;
        inst_addr = 32'h60;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write, inst_resp, data_resp, mem_mbe, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_values got rd=%b wr=%b ir=%b dr=%b mbe=%h addr=%h wdata=%h exp all 0",
                     mem_read, mem_write, inst_resp, data_resp, mem_mbe, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #3;
        tests++;
        if (mem_read !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_strobe got mem_read=%b exp 1", mem_read);
        end
        rst = 1'b1;
        mem_resp = 1'b1;
        #1;
        tests++;
        if ({mem_read, mem_write, inst_resp, data_resp, mem_mbe, mem_addr, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_async got rd=%b wr=%b ir=%b dr=%b mbe=%h addr=%h wdata=%h exp all 0",
                     mem_read, mem_write, inst_resp, data_resp, mem_mbe, mem_addr, mem_wdata);
        end
        inst_read = 1'b0;
        mem_resp = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({mem_read, mem_write, inst_resp, data_resp, mem_mbe, mem_addr, mem_wdata} !== '0) begin
                fails++;
                $display("FAIL reset_release cyc=%0d got rd=%b wr=%b ir=%b dr=%b mbe=%h addr=%h exp all 0",
                         c, mem_read, mem_write, inst_resp, data_resp, mem_mbe, mem_addr);
            end
            next_cycle();
        end
    endtask

    task automatic test_lone_fetch();
        int pulses;
        pulses = 0;
        inst_read = 1'b1;
        inst_addr = 32'h60;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write} !== 2'b00) begin
            fails++;
            $display("FAIL fetch_cycle0 got rd=%b wr=%b exp 00", mem_read, mem_write);
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            mem_resp  = (c == 4);
            mem_rdata = (c == 4) ? 32'h0000_0013 : 32'hAAAA_5555;
            @(negedge clk);
            tests++;
            if ({mem_read, mem_write, mem_addr, mem_mbe, data_resp} !== {2'b10, 32'h60, 4'b1111, 1'b0}) begin
                fails++;
                $display("FAIL fetch_drive cyc=%0d got rd=%b wr=%b addr=%h mbe=%b dr=%b exp 1 0 60 1111 0",
                         c, mem_read, mem_write, mem_addr, mem_mbe, data_resp);
            end
            tests++;
            if (inst_resp !== (c == 4)) begin
                fails++;
                $display("FAIL fetch_resp cyc=%0d got %b exp %b", c, inst_resp, (c == 4));
            end
            if (inst_resp === 1'b1) pulses++;
        end
        tests++;
        if (inst_rdata !== 32'h13) begin
            fails++;
            $display("FAIL fetch_rdata got %h exp 00000013", inst_rdata);
        end
        next_cycle();
        inst_read = 1'b0;
        mem_resp  = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000 || pulses != 1) begin
            fails++;
            $display("FAIL fetch_end got rd=%b wr=%b ir=%b dr=%b pulses=%0d exp 0000 pulses=1",
                     mem_read, mem_write, inst_resp, data_resp, pulses);
        end
        next_cycle();
    endtask

    task automatic test_store();
        data_write = 1'b1;
        data_addr  = 32'h100;
        data_wdata = 32'hDEAD_BEEF;
        data_mbe   = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 2) data_wdata = 32'h0;
            mem_resp = (c == 3);
            @(negedge clk);
            tests++;
            if ({mem_read, mem_write, mem_addr, mem_wdata, mem_mbe} !== {2'b01, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
                fails++;
                $display("FAIL store_drive cyc=%0d got rd=%b wr=%b addr=%h wdata=%h mbe=%b exp 0 1 100 deadbeef 0011",
                         c, mem_read, mem_write, mem_addr, mem_wdata, mem_mbe);
            end
            tests++;
            if ({inst_resp, data_resp} !== {1'b0, (c == 3)}) begin
                fails++;
                $display("FAIL store_resp cyc=%0d got ir=%b dr=%b exp 0 %b", c, inst_resp, data_resp, (c == 3));
            end
        end
        next_cycle();
        data_write = 1'b0;
        mem_resp   = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write, data_resp} !== 3'b000) begin
            fails++;
            $display("FAIL store_end got rd=%b wr=%b dr=%b exp 000", mem_read, mem_write, data_resp);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        int exp_own [8] = '{0, 2, 0, 1, 0, 2, 0, 1};
        inst_read = 1'b1;
        inst_addr = 32'h1000;
        data_read = 1'b1;
        data_addr = 32'h2000;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            mem_resp = (exp_own[c] != 0);
            @(negedge clk);
            tests++;
            if ({mem_read, mem_write} !== ((exp_own[c] != 0) ? 2'b10 : 2'b00) ||
                {inst_resp, data_resp} !== {exp_own[c] == 1, exp_own[c] == 2} ||
                (exp_own[c] != 0 && mem_addr !== ((exp_own[c] == 1) ? 32'h1000 : 32'h2000))) begin
                fails++;
                $display("FAIL contention cyc=%0d got rd=%b wr=%b ir=%b dr=%b addr=%h exp owner=%0d",
                         c, mem_read, mem_write, inst_resp, data_resp, mem_addr, exp_own[c]);
            end
            next_cycle();
        end
        inst_read = 1'b0;
        data_read = 1'b0;
        mem_resp  = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write} !== 2'b00) begin
            fails++;
            $display("FAIL contention_end got rd=%b wr=%b exp 00", mem_read, mem_write);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        data_read = 1'b1;
        data_addr = 32'h300;
        next_cycle();
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h300}) begin
            fails++;
            $display("FAIL rstmid_drive got rd=%b wr=%b addr=%h exp 1 0 300", mem_read, mem_write, mem_addr);
        end
        @(posedge clk);
        #4;
        mem_resp = 1'b1;
        rst = 1'b1;
        #1;
        tests++;
        if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_abort got rd=%b wr=%b ir=%b dr=%b exp 0000", mem_read, mem_write, inst_resp, data_resp);
        end
        data_read = 1'b0;
        mem_resp = 1'b0;
        next_cycle();
        rst = 1'b0;
        inst_read = 1'b1;
        inst_addr = 32'h400;
        next_cycle();
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_addr, inst_resp, data_resp, inst_rdata} !== {1'b1, 32'h400, 2'b10, 32'hCAFE_F00D}) begin
            fails++;
            $display("FAIL rstmid_fetch got rd=%b addr=%h ir=%b dr=%b rdata=%h exp 1 400 1 0 cafef00d",
                     mem_read, mem_addr, inst_resp, data_resp, inst_rdata);
        end
        next_cycle();
        inst_read = 1'b0;
        mem_resp  = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_end got rd=%b wr=%b ir=%b dr=%b exp 0000", mem_read, mem_write, inst_resp, data_resp);
        end
        next_cycle();
    endtask

    task automatic test_spurious_illegal();
        mem_resp = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
                fails++;
                $display("FAIL spurious cyc=%0d got rd=%b wr=%b ir=%b dr=%b exp 0000",
                         c, mem_read, mem_write, inst_resp, data_resp);
            end
            next_cycle();
        end
        mem_resp   = 1'b0;
        data_read  = 1'b1;
        data_write = 1'b1;
        data_addr  = 32'h500;
        data_wdata = 32'h1234_5678;
        data_mbe   = 4'b1010;
        next_cycle();
        @(negedge clk);
        tests++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, mem_mbe} !== {2'b01, 32'h500, 32'h1234_5678, 4'b1010}) begin
            fails++;
            $display("FAIL illegal_rw got rd=%b wr=%b addr=%h wdata=%h mbe=%b exp 0 1 500 12345678 1010",
                     mem_read, mem_write, mem_addr, mem_wdata, mem_mbe);
        end
        next_cycle();
        mem_resp = 1'b1;
        @(negedge clk);
        tests++;
        if ({inst_resp, data_resp} !== 2'b01) begin
            fails++;
            $display("FAIL illegal_resp got ir=%b dr=%b exp 0 1", inst_resp, data_resp);
        end
        next_cycle();
        data_read  = 1'b0;
        data_write = 1'b0;
        mem_resp   = 1'b0;
    endtask

    // Transaction-level model: a free port grants the sole requester, or the one not
    // granted last time; the grant is visible one cycle later and lasts until mem_resp.
    task automatic test_random();
        int          owner;
        bit          last_was_data;
        bit          ip, dp, dwr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mbe;
        bit          e_wr;
        int          lat, waited;
        owner = 0; last_was_data = 1'b0; ip = 1'b0; dp = 1'b0; dwr = 1'b0;
        e_addr = '0; e_wdata = '0; e_mbe = '0; e_wr = 1'b0; lat = 1; waited = 0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1;
                inst_addr = $urandom;
            end else if (!ip) begin
                inst_addr = $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1;
                dwr = $urandom_range(0, 1);
                data_addr = $urandom;
                data_wdata = $urandom;
                data_mbe = 4'($urandom);
            end else if (!dp) begin
                data_addr = $urandom;
                data_wdata = $urandom;
            end
            inst_read  = ip;
            data_read  = dp && !dwr;
            data_write = dp && dwr;
            mem_rdata  = $urandom;
            mem_resp   = (owner != 0) ? (waited == lat) : ($urandom_range(0, 3) == 0);
            @(negedge clk);
            tests++;
            if (owner == 0) begin
                if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
                    fails++;
                    $display("FAIL rand_idle cyc=%0d got rd=%b wr=%b ir=%b dr=%b exp 0000",
                             c, mem_read, mem_write, inst_resp, data_resp);
                end
            end else begin
                if ({mem_read, mem_write} !== {!e_wr, e_wr} || mem_addr !== e_addr ||
                    ((owner == 1 || e_wr) && {mem_wdata, mem_mbe} !== {e_wdata, e_mbe}) ||
                    {inst_resp, data_resp} !== {owner == 1 && mem_resp, owner == 2 && mem_resp} ||
                    (mem_resp && {inst_rdata, data_rdata} !== {mem_rdata, mem_rdata})) begin
                    fails++;
                    $display("FAIL rand_busy cyc=%0d owner=%0d got rd=%b wr=%b addr=%h wdata=%h mbe=%b ir=%b dr=%b exp wr=%b addr=%h wdata=%h mbe=%b resp=%b",
                             c, owner, mem_read, mem_write, mem_addr, mem_wdata, mem_mbe, inst_resp, data_resp,
                             e_wr, e_addr, e_wdata, e_mbe, mem_resp);
                end
            end
            if (owner == 0) begin
                if (ip || dp) begin
                    owner = (ip && (!dp || last_was_data)) ? 1 : 2;
                    last_was_data = (owner == 2);
                    e_addr  = (owner == 1) ? inst_addr : data_addr;
                    e_wdata = (owner == 1) ? 32'h0 : data_wdata;
                    e_mbe   = (owner == 1) ? 4'b1111 : data_mbe;
                    e_wr    = (owner == 2) && dwr;
                    lat     = $urandom_range(1, 4);
                    waited  = 1;
                end
            end else if (mem_resp) begin
                if (owner == 1) ip = 1'b0;
                else dp = 1'b0;
                owner = 0;
            end else begin
                waited++;
            end
            next_cycle();
        end
        inst_read = 1'b0;
        data_read = 1'b0;
        data_write = 1'b0;
        mem_resp = (owner != 0);
        repeat (2) next_cycle();
        mem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store();
        test_contention();
        test_reset_mid();
        test_spurious_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
